// File: rtl/fmin_2_pkg.sv
// Shared binary32 definitions for the FP ALU: field widths, the canonical NaN,
// the operand view and the per-operand class flags.
package fp_pkg;

  localparam int FLEN   = 32;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;

  localparam logic [FLEN-1:0] CANON_NAN = 32'h7FC0_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  typedef struct packed {
    logic is_nan;
    logic is_snan;
    logic is_zero;
  } fp_class_t;

endpackage

// File: rtl/fmin_2_classify.sv
// Combinational binary32 classifier producing NaN / signalling-NaN / zero flags.
// The sign bit plays no part in the class, so only exponent and mantissa come in.
module fp_classify
  import fp_pkg::*;
(
  input  logic [EXP_W-1:0]  exp,
  input  logic [MANT_W-1:0] mant,
  output fp_class_t         cls
);

  logic exp_max;
  logic mant_zero;

  assign exp_max   = (exp == '1);
  assign mant_zero = (mant == '0);

  assign cls.is_nan  = exp_max && !mant_zero;
  assign cls.is_snan = exp_max && !mant_zero && !mant[MANT_W-1];
  assign cls.is_zero = (exp == '0) && mant_zero;

endmodule

// File: rtl/fmin_2.sv
// Registered binary32 minimum with RISC-V FMIN.S semantics, one-cycle latency.
// Optional invalid-operation flag output enabled by defining FMIN_NV_FLAG_EN.
module fmin_2
  import fp_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Fmin_en,
  input  logic [FLEN-1:0] read_data1,
  input  logic [FLEN-1:0] read_data2,
  output logic [FLEN-1:0] mindata_out
`ifdef FMIN_NV_FLAG_EN
  ,
  output logic            fflags_nv
`endif
);

  fp32_t     op_a;
  fp32_t     op_b;
  fp_class_t cls_a;
  fp_class_t cls_b;
  logic      nan_a;
  logic      nan_b;
  logic [FLEN-1:0] min_val;

  assign op_a = read_data1;
  assign op_b = read_data2;

  fp_classify u_cls_a (
    .exp  (op_a.exp),
    .mant (op_a.mant),
    .cls  (cls_a)
  );

  fp_classify u_cls_b (
    .exp  (op_b.exp),
    .mant (op_b.mant),
    .cls  (cls_b)
  );

  // Signalling NaNs are a subset of NaNs; both select identically for the result.
  assign nan_a = cls_a.is_nan | cls_a.is_snan;
  assign nan_b = cls_b.is_nan | cls_b.is_snan;

  // Magnitudes compare as unsigned {exp,mant}; for negatives the larger magnitude wins.
  always_comb begin
    min_val = read_data1;
    if (nan_a && nan_b) begin
      min_val = CANON_NAN;
    end else if (nan_a) begin
      min_val = read_data2;
    end else if (nan_b) begin
      min_val = read_data1;
    end else if (cls_a.is_zero && cls_b.is_zero) begin
      min_val = {op_a.sign | op_b.sign, {(FLEN-1){1'b0}}};
    end else if (op_a.sign != op_b.sign) begin
      min_val = op_a.sign ? read_data1 : read_data2;
    end else if (op_a.sign) begin
      min_val = (read_data1[FLEN-2:0] >= read_data2[FLEN-2:0]) ? read_data1 : read_data2;
    end else begin
      min_val = (read_data1[FLEN-2:0] <= read_data2[FLEN-2:0]) ? read_data1 : read_data2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mindata_out <= '0;
    end else if (Fmin_en) begin
      mindata_out <= min_val;
    end else begin
      mindata_out <= '0;
    end
  end

`ifdef FMIN_NV_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags_nv <= 1'b0;
    end else begin
      fflags_nv <= Fmin_en && (cls_a.is_snan || cls_b.is_snan);
    end
  end
`endif

endmodule

// File: tb/tb_fmin_2.sv
// Self-checking bench for fmin_2: directed vectors plus randomized operands
// compared against a total-order reference model.
module tb_fmin_2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Fmin_en = 1'b0;
  logic [31:0] read_data1 = '0;
  logic [31:0] read_data2 = '0;
  logic [31:0] mindata_out;
`ifdef FMIN_NV_FLAG_EN
  logic        fflags_nv;
`endif

  int errors = 0;
  int checks = 0;

  fmin_2 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Fmin_en     (Fmin_en),
    .read_data1  (read_data1),
    .read_data2  (read_data2),
    .mindata_out (mindata_out)
`ifdef FMIN_NV_FLAG_EN
    ,
    .fflags_nv   (fflags_nv)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit m_is_nan(logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic bit m_is_snan(logic [31:0] x);
    return m_is_nan(x) && !x[22];
  endfunction

  // Map every non-NaN value onto a signed integer line: -0 sits just below +0.
  function automatic longint m_key(logic [31:0] x);
    longint mag;
    mag = longint'(x[30:0]);
    return x[31] ? (-mag - 1) : mag;
  endfunction

  function automatic logic [31:0] m_min(logic [31:0] a, logic [31:0] b);
    if (m_is_nan(a) && m_is_nan(b)) return 32'h7FC0_0000;
    if (m_is_nan(a)) return b;
    if (m_is_nan(b)) return a;
    return (m_key(a) <= m_key(b)) ? a : b;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    logic        s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 6))
      0: v = {s, 8'hFF, 1'b1, 22'($urandom)};
      1: v = {s, 8'hFF, 1'b0, 22'($urandom) | 22'd1};
      2: v = {s, 31'd0};
      3: v = {s, 8'hFF, 23'd0};
      4: v = {s, 8'h00, 23'($urandom)};
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(string tag, logic en, logic [31:0] a, logic [31:0] b);
    logic [31:0] exp_val;
    @(negedge clk);
    Fmin_en    = en;
    read_data1 = a;
    read_data2 = b;
    exp_val = en ? m_min(a, b) : 32'd0;
    @(posedge clk);
    #1;
    check(tag, mindata_out, exp_val);
`ifdef FMIN_NV_FLAG_EN
    check({tag, "_nv"}, {31'd0, fflags_nv},
          {31'd0, en && (m_is_snan(a) || m_is_snan(b))});
`endif
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;

    #1;
    check("reset_async", mindata_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    step("same_subnormal", 1'b1, 32'h0000_EF12, 32'h0000_EF12);
    check("same_subnormal_const", mindata_out, 32'h0000_EF12);
    step("sign_diff_b_neg", 1'b1, 32'h0234_EF12, 32'hF234_DF12);
    check("sign_diff_b_neg_const", mindata_out, 32'hF234_DF12);
    step("sign_diff_a_neg", 1'b1, 32'hF811_AB12, 32'h0F42_AB12);
    step("both_neg", 1'b1, 32'hA156_BF12, 32'hB9FA_6BF2);
    check("both_neg_const", mindata_out, 32'hB9FA_6BF2);
    step("subnormal_vs_normal", 1'b1, 32'h000E_F0E2, 32'h00EF_90E2);
    check("subnormal_vs_normal_const", mindata_out, 32'h000E_F0E2);

    step("enable_low", 1'b0, 32'h0000_ED12, 32'h000E_BA12);
    check("enable_low_const", mindata_out, 32'd0);
    step("enable_resume", 1'b1, 32'h0000_ED12, 32'h000E_BA12);

    step("qnan_a", 1'b1, 32'h7FF1_2001, 32'h0000_0123);
    check("qnan_a_const", mindata_out, 32'h0000_0123);
    step("qnan_b", 1'b1, 32'hC000_0000, 32'hFFC0_0001);
    step("both_nan", 1'b1, 32'h7F80_0001, 32'h7FC0_0005);
    check("both_nan_const", mindata_out, 32'h7FC0_0000);

    step("zero_pos_neg", 1'b1, 32'h0000_0000, 32'h8000_0000);
    check("zero_pos_neg_const", mindata_out, 32'h8000_0000);
    step("zero_neg_pos", 1'b1, 32'h8000_0000, 32'h0000_0000);
    step("zero_pos_pos", 1'b1, 32'h0000_0000, 32'h0000_0000);

    step("inf_neg_pos", 1'b1, 32'hFF80_0000, 32'h7F80_0000);
    check("inf_neg_pos_const", mindata_out, 32'hFF80_0000);
    step("inf_pos_vs_max", 1'b1, 32'h7F80_0000, 32'h7F7F_FFFF);

    // Reset in the middle of a live result must clear it without a clock edge.
    step("pre_reset", 1'b1, 32'h3F80_0000, 32'h4000_0000);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid", mindata_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset", 1'b1, 32'h4000_0000, 32'h3F80_0000);

    // Back-to-back random operands, one per cycle, with occasional enable drops.
    for (int i = 0; i < 300; i++) begin
      ra = rand_op();
      rb = ($urandom_range(0, 7) == 0) ? ra : rand_op();
      step("random", ($urandom_range(0, 9) != 0), ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
